// File: rtl/uart_rx_if.sv
// Serial-receive bundle between the line/enable side (master) and uart_rx (slave).
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 clk_en;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 rx_strobe;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output clk_en,
    output rx,
    input  data,
    input  rx_strobe,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  clk_en,
    input  rx,
    output data,
    output rx_strobe,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// MIDI 8N1 serial receiver: oversampled, 3-sample majority vote,
// one-clk strobe per good byte, one-clk frame_err on a low stop bit.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [2:0]           hist_q, hist_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rx_strobe_q, rx_strobe_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic                 vote;

  // Majority of the three most recent enabled samples.
  always_comb begin
    vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  end

  // Next-state logic: synchronizer every clk, everything else only on clk_en.
  always_comb begin
    rx_meta_d   = bus.rx;
    rx_s_d      = rx_meta_q;
    hist_d      = hist_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rx_strobe_d = 1'b0;
    frame_err_d = 1'b0;

    if (bus.clk_en) begin
      hist_d = {hist_q[1:0], rx_s_q};
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end

        S_START: begin
          if (cnt_q == CNT_HALF) begin
            if (vote) begin
              state_d = S_IDLE;
            end else begin
              state_d   = S_DATA;
              cnt_d     = '0;
              bit_cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          // Explicit wrap keeps non-power-of-two OVERSAMPLE values correct.
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            shift_d   = {vote, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_d = S_STOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (vote) begin
              data_d      = shift_q;
              rx_strobe_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_WAIT_HIGH: begin
          // A held-low (break) line must not be taken as a new start bit.
          if (vote) begin
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      hist_q      <= '1;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rx_strobe_q <= rx_strobe_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.rx_strobe = rx_strobe_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: frames are built from the 8N1
// line rules and compared against an expected-byte queue.
module tb_uart_rx;

  localparam int unsigned OS = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] got_q[$];
  logic [7:0] want_q[$];
  int         fe_total   = 0;
  int         width_err  = 0;
  logic       prev_strobe = 1'b0;
  logic       prev_fe     = 1'b0;

  // Record every strobe/frame_err observed away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_strobe === 1'b1) got_q.push_back(bus.data);
    if (bus.frame_err === 1'b1) fe_total++;
    if ((bus.rx_strobe === 1'b1) && prev_strobe) width_err++;
    if ((bus.frame_err === 1'b1) && prev_fe) width_err++;
    prev_strobe = (bus.rx_strobe === 1'b1);
    prev_fe     = (bus.frame_err === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One sample period: four clks with a single clk_en pulse; rx settles
  // through the synchronizer before the enabled edge.
  task automatic period(input logic v);
    bus.rx     = v;
    bus.clk_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.clk_en = 1'b1;
    @(negedge clk);
    bus.clk_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) period(1'b1);
  endtask

  // Line level of frame sample j: start bit, data LSB first, stop bit.
  function automatic logic frame_level(input logic [7:0] b, input logic stop, input int j);
    int bp;
    bp = j / OS;
    if (bp == 0) return 1'b0;
    if (bp <= 8) return b[bp-1];
    return stop;
  endfunction

  // Drive samples [0, upto) of a frame; flip inverts one sample (-1: none).
  task automatic send_part(input logic [7:0] b, input logic stop, input int flip, input int upto);
    logic v;
    for (int j = 0; j < upto; j++) begin
      v = frame_level(b, stop, j);
      if (j == flip) v = ~v;
      period(v);
      if (j == 5 * OS) check("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int flip);
    send_part(b, stop, flip, 10 * OS);
  endtask

  task automatic check_rx(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), want_q.size());
    n = (got_q.size() < want_q.size()) ? got_q.size() : want_q.size();
    for (int i = 0; i < n; i++) check({tag, "_data"}, {24'd0, got_q[i]}, {24'd0, want_q[i]});
    got_q.delete();
    want_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},      {24'd0, bus.data},      32'd0);
    check({tag, "_rx_strobe"}, {31'd0, bus.rx_strobe}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
    check({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
  endtask

  logic [7:0] last_good;
  logic [7:0] rb;
  int         flip;

  initial begin
    bus.rx     = 1'b1;
    bus.clk_en = 1'b0;
    rst        = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(4);

    // Single byte
    send_frame(8'h90, 1'b1, -1);
    want_q.push_back(8'h90);
    idle(1);
    check("single_busy_after", {31'd0, bus.busy}, 32'd0);
    check("single_data_port", {24'd0, bus.data}, 32'h90);
    check_rx("single");
    check("single_no_ferr", fe_total, 0);

    // Back-to-back, no idle gap
    send_frame(8'h90, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'h7F, 1'b1, -1);
    want_q.push_back(8'h90);
    want_q.push_back(8'h3C);
    want_q.push_back(8'h7F);
    idle(2);
    check_rx("b2b");
    check("b2b_no_ferr", fe_total, 0);

    // One-sample glitch on idle line
    period(1'b0);
    idle(16);
    check_rx("glitch");
    check("glitch_busy", {31'd0, bus.busy}, 32'd0);
    check("glitch_data_kept", {24'd0, bus.data}, 32'h7F);

    // Inverted sample inside data bit 3 of 0x55 (frame bit 4, within vote window)
    send_frame(8'h55, 1'b1, 4 * OS + 3);
    want_q.push_back(8'h55);
    idle(2);
    check_rx("vote55");
    last_good = 8'h55;

    // Framing error then 20 bit periods of break
    send_frame(8'hA5, 1'b0, -1);
    for (int i = 0; i < 20 * OS; i++) period(1'b0);
    check("ferr_busy_held", {31'd0, bus.busy}, 32'd1);
    check("ferr_count", fe_total, 1);
    check("ferr_data_kept", {24'd0, bus.data}, {24'd0, last_good});
    check_rx("ferr_no_strobe");
    idle(4);
    check("ferr_busy_release", {31'd0, bus.busy}, 32'd0);
    send_frame(8'h12, 1'b1, -1);
    want_q.push_back(8'h12);
    idle(2);
    check_rx("after_ferr");

    // Reset during data bit 4 of 0x80, then line returns idle
    send_part(8'h80, 1'b1, -1, 5 * OS + 4);
    bus.rx = 1'b1;
    rst    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b1;
    idle(12);
    check_rx("midreset_no_strobe");
    check("midreset_data", {24'd0, bus.data}, 32'd0);
    send_frame(8'hF0, 1'b1, -1);
    want_q.push_back(8'hF0);
    idle(2);
    check_rx("after_reset");

    // Random bytes, random small gaps, optional single flipped data sample
    for (int k = 0; k < 24; k++) begin
      rb   = 8'($urandom);
      flip = ($urandom_range(0, 1) == 1) ? int'(OS + $urandom_range(0, 8 * OS - 1)) : -1;
      send_frame(rb, 1'b1, flip);
      want_q.push_back(rb);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);
    check_rx("random");

    check("pulse_width", width_err, 0);
    check("ferr_total", fe_total, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
